// File: rtl/phy_rx_pkg.sv
// phy_rx_pkg: shared types and constants for the PHY receive deframer.
// The PRE and DROP states are only used when PHY_RX_PREAMBLE_STRIP_EN is defined.
package phy_rx_pkg;

    typedef enum logic [2:0] {
        WAIT_IDLE = 3'd0,
        IDLE      = 3'd1,
        PRE       = 3'd2,
        LO        = 3'd3,
        HI        = 3'd4,
        END       = 3'd5,
        DROP      = 3'd6
    } state_t;

    localparam logic [3:0] PREAMBLE_NIB = 4'h5;
    localparam logic [3:0] SFD_NIB      = 4'hD;

    typedef struct packed {
        logic runt;
        logic giant;
        logic align;
    } err_flags_t;

endpackage

// File: rtl/frame_len_checker.sv
// frame_len_checker: saturating per-frame byte counter with min/max length
// comparators. Produces the running count, an early "next byte is over the
// limit" indication and the final error flags for the frame being closed.
module frame_len_checker
    import phy_rx_pkg::*;
#(
    parameter int LEN_W   = 12,
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 2047
) (
    input  logic             clk_phy,
    input  logic             reset,
    input  logic             inc,
    input  logic             clear,
    input  logic             align_in,
    output logic [LEN_W-1:0] count,
    output logic             over_max,
    output err_flags_t       flags
);

    localparam logic [LEN_W-1:0] MIN_L   = LEN_W'(MIN_LEN);
    localparam logic [LEN_W-1:0] MAX_L   = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] SAT_MAX = '1;

    logic [LEN_W-1:0] count_reg;

    // Count completed bytes, stick at all-ones, clear between frames.
    always_ff @(posedge clk_phy or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (inc && (count_reg != SAT_MAX)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    // Comparators: over_max looks one byte ahead so the byte that would push
    // the length past MAX_LEN is already suppressed.
    always_comb begin
        count       = count_reg;
        over_max    = (count_reg >= MAX_L);
        flags.runt  = (count_reg < MIN_L);
        flags.giant = (count_reg > MAX_L);
        flags.align = align_in;
    end

endmodule

// File: rtl/phy_rx_deframer.sv
// phy_rx_deframer: reassembles low-nibble-first bytes from the PHY nibble
// stream, delimits frames on phy_tx_en and reports length/error status.
// Optional preamble/SFD stripping is enabled by defining PHY_RX_PREAMBLE_STRIP_EN.
module phy_rx_deframer
    import phy_rx_pkg::*;
#(
    parameter int LEN_W   = 12,
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 2047,
    parameter int CNT_W   = 16
) (
    input  logic             clk_phy,
    input  logic             reset,
    input  logic [3:0]       phy_data_in,
    input  logic             phy_tx_en,
    output logic [7:0]       rx_data,
    output logic             rx_data_valid,
    output logic             rx_frame_start,
    output logic             rx_frame_end,
    output logic [LEN_W-1:0] rx_frame_len,
    output logic             rx_err_runt,
    output logic             rx_err_giant,
    output logic             rx_err_align,
    output logic [CNT_W-1:0] rx_good_count
);

    state_t           state_reg;
    state_t           state_next;
    state_t           start_state;

    logic [3:0]       nib_latch_reg;
    logic [7:0]       rx_data_reg;
    logic             rx_data_valid_reg;
    logic             rx_frame_start_reg;
    logic [LEN_W-1:0] rx_frame_len_reg;
    err_flags_t       err_reg;
    logic [CNT_W-1:0] good_count_reg;

    logic             latch_en;
    logic             byte_done;
    logic             frame_close;
    logic             close_align;
    logic             len_clear;
    logic             frame_end;

    logic [LEN_W-1:0] len_count;
    logic             len_over_max;
    err_flags_t       len_flags;

    frame_len_checker #(
        .LEN_W   (LEN_W),
        .MIN_LEN (MIN_LEN),
        .MAX_LEN (MAX_LEN)
    ) u_len_checker (
        .clk_phy  (clk_phy),
        .reset    (reset),
        .inc      (byte_done),
        .clear    (len_clear),
        .align_in (close_align),
        .count    (len_count),
        .over_max (len_over_max),
        .flags    (len_flags)
    );

    // State register.
    always_ff @(posedge clk_phy or negedge reset) begin
        if (!reset) begin
            state_reg <= WAIT_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic. The first nibble of an envelope is consumed by the
    // transition out of IDLE/END, so start_state says where that nibble goes.
    always_comb begin
        start_state = HI;
`ifdef PHY_RX_PREAMBLE_STRIP_EN
        if (phy_data_in == PREAMBLE_NIB) begin
            start_state = PRE;
        end else if (phy_data_in == SFD_NIB) begin
            start_state = LO;
        end else begin
            start_state = DROP;
        end
`endif
        state_next = state_reg;
        case (state_reg)
            WAIT_IDLE: if (!phy_tx_en) state_next = IDLE;
            IDLE:      if (phy_tx_en) state_next = start_state;
            LO:        state_next = phy_tx_en ? HI : END;
            HI:        state_next = phy_tx_en ? LO : END;
            END:       state_next = phy_tx_en ? start_state : IDLE;
`ifdef PHY_RX_PREAMBLE_STRIP_EN
            PRE:       state_next = phy_tx_en ? start_state : DROP;
            DROP:      if (!phy_tx_en) state_next = END;
`endif
            default:   state_next = WAIT_IDLE;
        endcase
    end

    // Control strobes derived from the current and next state.
    always_comb begin
        latch_en    = (state_next == HI);
        byte_done   = (state_reg == HI) && phy_tx_en;
        frame_close = (state_next == END);
        close_align = (state_reg == HI) || (state_reg == DROP);
        len_clear   = (state_reg == END);
        frame_end   = (state_reg == END);
    end

    // Datapath: nibble latch, byte register, and frame status captured on close.
    always_ff @(posedge clk_phy or negedge reset) begin
        if (!reset) begin
            nib_latch_reg      <= '0;
            rx_data_reg        <= '0;
            rx_data_valid_reg  <= 1'b0;
            rx_frame_start_reg <= 1'b0;
            rx_frame_len_reg   <= '0;
            err_reg            <= '0;
            good_count_reg     <= '0;
        end else begin
            if (latch_en) begin
                nib_latch_reg <= phy_data_in;
            end
            rx_data_valid_reg  <= byte_done && !len_over_max;
            rx_frame_start_reg <= byte_done && !len_over_max && (len_count == '0);
            if (byte_done && !len_over_max) begin
                rx_data_reg <= {phy_data_in, nib_latch_reg};
            end
            if (frame_close) begin
                rx_frame_len_reg <= len_count;
                err_reg          <= len_flags;
                if (len_flags == '0) begin
                    good_count_reg <= good_count_reg + 1'b1;
                end
            end
        end
    end

    assign rx_data        = rx_data_reg;
    assign rx_data_valid  = rx_data_valid_reg;
    assign rx_frame_start = rx_frame_start_reg;
    assign rx_frame_end   = frame_end;
    assign rx_frame_len   = rx_frame_len_reg;
    assign rx_err_runt    = err_reg.runt;
    assign rx_err_giant   = err_reg.giant;
    assign rx_err_align   = err_reg.align;
    assign rx_good_count  = good_count_reg;

endmodule
